// File: rtl/cp0_pkg.sv
// Shared definitions for the coprocessor-0 responder.
// Holds the CP0 register indices, the status/cause bit positions and the
// state encodings used by the interrupt/return sequencer.
package cp0_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;

  localparam int SR_IE    = 0;
  localparam int SR_EXL   = 1;
  localparam int CAUSE_IP = 10;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_TAKE    = 2'd1;
  localparam logic [1:0] ST_HANDLER = 2'd2;
  localparam logic [1:0] ST_RET     = 2'd3;

  typedef enum logic [1:0] {
    RUN     = ST_RUN,
    TAKE    = ST_TAKE,
    HANDLER = ST_HANDLER,
    RET     = ST_RET
  } cp0_state_e;

endpackage

// File: rtl/cp0.sv
// Coprocessor-0 responder for the 5-stage MIPS pipeline.
// Services MFC0 reads / MTC0 writes from ID, latches a rising edge of the
// external interrupt request into CAUSE.IP, and sequences interrupt entry
// and ERET return by redirecting the IF stage.
// Ports:
//   clk, rst            clock, async active-high reset
//   en                  ID-stage enable (low = pipeline stalled)
//   addr_r / data_r     MFC0 index and combinational read data
//   wen, addr_w, data_w MTC0 commit strobe, index and data
//   eret                ERET decoded in ID
//   ir_en               datapath permits interrupt entry this cycle
//   ret_addr            resume PC captured into EPC on trap entry
//   ir_in               external interrupt request (level, synchronous)
//   jump_en, jump_addr  PC redirect request and target
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_RESET = 32'h0000_0008,
  parameter logic [4:0]  EHBR_ADDR     = 5'd25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [4:0]  addr_r,
  output logic [31:0] data_r,
  input  logic        wen,
  input  logic [4:0]  addr_w,
  input  logic [31:0] data_w,
  input  logic        eret,
  input  logic        ir_en,
  input  logic [31:0] ret_addr,
  input  logic        ir_in,
  output logic        jump_en,
  output logic [31:0] jump_addr
);

  logic [31:0] regs [32];
  cp0_state_e  state, state_next;

  logic ir_d;
  logic ir_rise;
  logic ip, ie, exl;
  logic take;
  logic mtc0_ok;
  logic ip_clear;
  logic ip_next;
  logic ret_exit;

  assign ip  = regs[CP0_CAUSE][CAUSE_IP];
  assign ie  = regs[CP0_SR][SR_IE];
  assign exl = regs[CP0_SR][SR_EXL];

  assign ir_rise  = ir_in & ~ir_d;
  assign take     = (state == RUN) & ip & ie & ~exl & ir_en & en;
  // Software writes are frozen while a redirect is being presented to IF.
  assign mtc0_ok  = wen & en & ((state == RUN) | (state == HANDLER));
  assign ret_exit = (state == RET) & en;
  assign ip_clear = take | (mtc0_ok & (addr_w == CP0_CAUSE) & data_w[CAUSE_IP]);
  // A fresh request edge beats any clear landing in the same cycle.
  assign ip_next  = ir_rise | (ip & ~ip_clear);

  // Read data comes straight off the array, so a same-cycle write is not seen.
  always_comb begin
    data_r = '0;
    if (addr_r != 5'd0) data_r = regs[addr_r];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Redirect outputs decode purely from the state register, so they are
  // glitch-free and drop as soon as reset forces the state back to RUN.
  always_comb begin
    state_next = state;
    jump_en    = 1'b0;
    jump_addr  = '0;
    unique case (state)
      RUN: begin
        if (take)             state_next = TAKE;
        else if (eret && en)  state_next = RET;
      end
      TAKE: begin
        jump_en   = 1'b1;
        jump_addr = regs[EHBR_ADDR];
        if (en) state_next = HANDLER;
      end
      HANDLER: begin
        if (eret && en) state_next = RET;
      end
      RET: begin
        jump_en   = 1'b1;
        jump_addr = regs[CP0_EPC];
        if (en) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ir_d <= 1'b0;
    else     ir_d <= ir_in;
  end

  // Later assignments deliberately override the generic MTC0 write:
  // trap capture owns EPC and EXL, and CAUSE.IP is only ever set by an
  // edge or cleared by acceptance / write-1-to-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= (5'(i) == EHBR_ADDR) ? HANDLER_RESET : 32'h0;
      end
    end else begin
      if (mtc0_ok && (addr_w != 5'd0)) regs[addr_w] <= data_w;
      if (take) begin
        regs[CP0_EPC]         <= ret_addr;
        regs[CP0_SR][SR_EXL]  <= 1'b1;
      end
      if (ret_exit) regs[CP0_SR][SR_EXL] <= 1'b0;
      regs[CP0_CAUSE][CAUSE_IP] <= ip_next;
    end
  end

endmodule

// File: doc/cp0.md
# cp0

Coprocessor-0 responder for the 5-stage MIPS pipeline: it services MFC0 reads and MTC0 writes issued from the ID stage, latches an external interrupt request, and arbitrates interrupt entry and ERET return. It drives the PC-redirect pair (`jump_en`, `jump_addr`) back into the IF stage. It sits beside the datapath and is sequenced by the controller's ID-stage enable.

## Interface
Parameters:
- `HANDLER_RESET`, default 32'h0000_0008: reset value of the handler-base register.
- `EHBR_ADDR`, default 5'd25: CP0 index of the handler-base register.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `en`  in  1  ID-stage enable. Accepts MTC0, ERET and trap entry/exit only when high; low means the pipeline is stalled.
- `addr_r`  in  5  MFC0 source index.
- `data_r`  out  32  MFC0 read data (combinational).
- `wen`  in  1  MTC0 commit strobe.
- `addr_w`  in  5  MTC0 destination index.
- `data_w`  in  32  MTC0 write data.
- `eret`  in  1  ERET decoded in ID.
- `ir_en`  in  1  datapath permits interrupt entry this cycle.
- `ret_addr`  in  32  resume PC supplied by the datapath.
- `ir_in`  in  1  external interrupt request, level, already synchronous to `clk`.
- `jump_en`  out  1  PC redirect request.
- `jump_addr`  out  32  PC redirect target.

## Operation
Register file:
- 32 × 32-bit registers.
- Special registers:
  - SR (12): bit0 = IE, bit1 = EXL.
  - CAUSE (13): bit10 = IP, read-only except via write-1-to-clear.
  - EPC (14).
  - EHBR (`EHBR_ADDR`).
- All other indices are plain storage.
- Index 0 reads 0.

Interrupt pending (IP):
- Set on an `ir_in` rising edge, detected with a one-flop delay register.
- Cleared on trap acceptance.
- Cleared by MTC0 to CAUSE with `data_w[10]`=1.
- If a set and a clear occur in the same cycle, the set wins.

States: RUN, TAKE, HANDLER, RET.
- RUN:
  - If IP & IE & ~EXL & `ir_en` & `en` all hold: EPC <= `ret_addr`, EXL <= 1, IP cleared, go to TAKE.
  - Otherwise, if `eret` & `en`: go to RET.
- TAKE:
  - `jump_en`=1, `jump_addr`=EHBR.
  - Held until `en`=1, then go to HANDLER.
- HANDLER:
  - IP accumulates; no nested entry.
  - On `eret` & `en`: go to RET.
- RET:
  - `jump_en`=1, `jump_addr`=EPC.
  - Held until `en`=1, then EXL <= 0 and go to RUN.

Outputs outside TAKE/RET: `jump_en`=0, `jump_addr`=0.

Writes:
- MTC0 applies only when `wen` & `en`.
- Trap capture of EPC/EXL in the same cycle as an MTC0 to SR/EPC: capture wins; the MTC0 still updates the other SR bits.
- MTC0 and ERET are ignored in TAKE and RET.

## Timing
- Reset values:
  - All registers 0, except EHBR = `HANDLER_RESET`.
  - State RUN, IP 0, edge-delay flop 0.
  - `jump_en` 0, `jump_addr` 0.
  - `data_r` reflects reset contents.
- Read path: `data_r` is combinational from `addr_r`. Read-during-write to the same index returns the old value; the new value is visible the next cycle.
- Trap latency:
  - `ir_in` edge at cycle N → IP visible at N+1.
  - Acceptance at the first edge ≥ N+1 where the RUN condition holds.
  - `jump_en` high the cycle after acceptance.
- `jump_en` is registered (decoded from state). It stays high for every cycle `en`=0 in TAKE/RET and drops the cycle after the `en`=1 edge.
- ERET return: `jump_en` high the cycle after ERET acceptance. EXL clears on the same edge that leaves RET.
- `rst` mid-TAKE/RET: state, `jump_en` and EXL clear immediately, asynchronously.
- `ir_in` held high continuously produces a single IP set (edge-triggered).

## Structure
- Shared package/header holds:
  - Register indices: CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14.
  - Bit positions: SR_IE=0, SR_EXL=1, CAUSE_IP=10.
  - State encodings: RUN/TAKE/HANDLER/RET as 2-bit localparams.
- Single module, no sub-modules. The register array is inline; the edge detector is two lines and does not justify its own module.

## Test plan
- Reset with `HANDLER_RESET`=8 → `data_r`(addr 25)=8, `jump_en`=0. Assert `rst` during RET → `jump_en` drops without waiting for a clock edge.
- MTC0 SR=3, EPC=0x100; MFC0 in the same cycle as the write → old value (0). Next cycle → 0x3 / 0x100. MFC0 of index 0 → 0.
- IE=1, `ir_in` pulse, `ret_addr`=0x40, `en`=1 → after 2 cycles `jump_en`=1, `jump_addr`=8. EPC=0x40, SR.EXL=1, CAUSE.IP=0.
- In TAKE, hold `en`=0 for 3 cycles → `jump_en` held for 3 cycles with target 8. Raise `en` → TAKE exits to HANDLER; `jump_en` drops next cycle.
- In HANDLER, second `ir_in` edge → no entry, CAUSE.IP=1. ERET → `jump_en`=1, `jump_addr`=0x40, EXL=0 after exit. Trap re-taken on the following cycle.
- IE=0 with an `ir_in` edge → IP=1, no trap. MTC0 CAUSE bit10=1 with a simultaneous new edge → IP remains 1. Repeat without the edge → IP=0.
